// File: rtl/otter_timer_counter.sv
// Memory-mapped timer/counter for the OTTER I/O bus: a 16-byte register window,
// a power-of-two prescaler, a terminal-count compare and a level interrupt.
module otter_timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_HIT,
  output logic        INTR
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_TERM   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  logic        r_en;
  logic        r_reload;
  logic        r_ie;
  logic [3:0]  r_ps;
  logic [31:0] r_term;
  logic [31:0] r_count;
  logic        r_pend;
  logic [15:0] r_presc;

  reg_sel_e    w_sel;
  logic        w_wr_ctrl;
  logic        w_wr_term;
  logic        w_wr_count;
  logic        w_wr_status;
  logic [15:0] w_ps_limit;
  logic        w_tick;
  logic        w_event;
  logic        w_unused;

  // Byte lane bits are irrelevant: only word accesses exist.
  assign w_unused = &{1'b0, IOBUS_ADDR[1:0]};

  assign RD_HIT      = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign w_sel       = reg_sel_e'(IOBUS_ADDR[3:2]);
  assign w_wr_ctrl   = IOBUS_WR && RD_HIT && (w_sel == REG_CTRL);
  assign w_wr_term   = IOBUS_WR && RD_HIT && (w_sel == REG_TERM);
  assign w_wr_count  = IOBUS_WR && RD_HIT && (w_sel == REG_COUNT);
  assign w_wr_status = IOBUS_WR && RD_HIT && (w_sel == REG_STATUS);

  assign w_ps_limit = (16'd1 << r_ps) - 16'd1;
  assign w_tick     = r_en && (r_presc == w_ps_limit);

  // A CTRL or COUNT write swallows a coincident tick, so no event can fire then.
  assign w_event = w_tick && (r_count == r_term) && !(w_wr_ctrl || w_wr_count);

  assign INTR = r_pend && r_ie;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_ie     <= 1'b0;
      r_ps     <= 4'd0;
      r_term   <= 32'd0;
      r_count  <= 32'd0;
      r_pend   <= 1'b0;
      r_presc  <= 16'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= IOBUS_OUT[0];
        r_reload <= IOBUS_OUT[1];
        r_ie     <= IOBUS_OUT[2];
        r_ps     <= IOBUS_OUT[11:8];
      end else if (w_event && !r_reload) begin
        r_en <= 1'b0;
      end

      if (w_wr_term) begin
        r_term <= IOBUS_OUT;
      end

      if (w_wr_count) begin
        r_count <= IOBUS_OUT;
      end else if (w_tick && !w_wr_ctrl) begin
        r_count <= w_event ? 32'd0 : r_count + 32'd1;
      end

      if (w_wr_ctrl || w_wr_count) begin
        r_presc <= 16'd0;
      end else if (r_en) begin
        r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      end

      // An event setting PEND beats a software clear in the same cycle.
      if (w_event) begin
        r_pend <= 1'b1;
      end else if (w_wr_status && IOBUS_OUT[0]) begin
        r_pend <= 1'b0;
      end
    end
  end

  // NOTE: RD_DATA gets a default before the case so no latch is inferred.
  always_comb begin
    RD_DATA = 32'd0;
    if (RD_HIT) begin
      case (w_sel)
        REG_CTRL:   RD_DATA = {20'd0, r_ps, 5'd0, r_ie, r_reload, r_en};
        REG_TERM:   RD_DATA = r_term;
        REG_COUNT:  RD_DATA = r_count;
        REG_STATUS: RD_DATA = {31'd0, r_pend};
        default:    RD_DATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_timer_counter.sv
// Directed bench for otter_timer_counter: reset, periodic, prescaled one-shot,
// bus/tick collisions, 32-bit wrap and address decode.
module tb_otter_timer_counter;

  localparam logic [31:0] BASE     = 32'h1100_0100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_TERM   = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        intr;

  int n_vec;
  int n_err;

  otter_timer_counter #(.BASE_ADDR(BASE)) dut (
    .CLK        (clk),
    .RST        (rst),
    .IOBUS_ADDR (addr),
    .IOBUS_OUT  (wdata),
    .IOBUS_WR   (wr),
    .RD_DATA    (rd_data),
    .RD_HIT     (rd_hit),
    .INTR       (intr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(posedge clk);
    #1;
    wr    = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    wr   = 1'b0;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    addr  = 32'd0;
    wdata = 32'd0;
    wr    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset: program, run briefly, then a one-cycle reset discards everything.
    bus_write(A_TERM, 32'd5);
    bus_write(A_CTRL, 32'h7);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reg("rst_ctrl",   A_CTRL,   32'h0);
    chk_reg("rst_term",   A_TERM,   32'h0);
    chk_reg("rst_count",  A_COUNT,  32'h0);
    chk_reg("rst_status", A_STATUS, 32'h0);
    check("rst_intr", {31'd0, intr}, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk_reg("rst_count_hold", A_COUNT, 32'h0);

    // Periodic: TERM=3, PS=0, reload, IE.
    bus_write(A_TERM, 32'd3);
    bus_write(A_CTRL, 32'h7);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk_reg($sformatf("per_count_e%0d", e), A_COUNT, 32'(e % 4));
      check($sformatf("per_intr_e%0d", e), {31'd0, intr}, (e == 4) ? 32'd1 : 32'd0);
    end
    chk_reg("per_pend", A_STATUS, 32'h1);
    bus_write(A_STATUS, 32'h1);
    chk_reg("per_clr_count", A_COUNT, 32'd1);
    check("per_clr_intr_e5", {31'd0, intr}, 32'd0);
    tick();
    check("per_clr_intr_e6", {31'd0, intr}, 32'd0);
    tick();
    check("per_clr_intr_e7", {31'd0, intr}, 32'd0);
    tick();
    check("per_intr_e8", {31'd0, intr}, 32'd1);
    chk_reg("per_count_e8", A_COUNT, 32'd0);

    // Prescale PS=2 one-shot: event at edge 12.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_write(A_TERM, 32'd2);
    bus_write(A_COUNT, 32'd0);
    bus_write(A_CTRL, 32'h205);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk_reg($sformatf("ps_count_e%0d", e), A_COUNT,
              (e < 4) ? 32'd0 : (e < 8) ? 32'd1 : (e < 12) ? 32'd2 : 32'd0);
      chk_reg($sformatf("ps_pend_e%0d", e), A_STATUS, (e == 12) ? 32'd1 : 32'd0);
    end
    check("ps_intr", {31'd0, intr}, 32'd1);
    chk_reg("ps_ctrl_oneshot", A_CTRL, 32'h204);
    for (int i = 0; i < 8; i++) tick();
    chk_reg("ps_count_hold", A_COUNT, 32'd0);
    check("ps_intr_hold", {31'd0, intr}, 32'd1);

    // Collision A: COUNT write on the terminal tick wins, no event.
    bus_write(A_STATUS, 32'h1);
    bus_write(A_TERM, 32'd3);
    bus_write(A_CTRL, 32'h3);
    tick();
    tick();
    tick();
    chk_reg("colA_pre_count", A_COUNT, 32'd3);
    bus_write(A_COUNT, 32'h10);
    chk_reg("colA_count", A_COUNT, 32'h10);
    chk_reg("colA_pend", A_STATUS, 32'd0);
    tick();
    chk_reg("colA_next", A_COUNT, 32'h11);

    // Collision B: STATUS clear on the event edge loses to the event.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_COUNT, 32'd0);
    bus_write(A_TERM, 32'd2);
    bus_write(A_CTRL, 32'h3);
    tick();
    tick();
    bus_write(A_STATUS, 32'h1);
    chk_reg("colB_pend", A_STATUS, 32'd1);
    chk_reg("colB_count", A_COUNT, 32'd0);

    // Wrap: COUNT above TERM runs through 2^32 with no event at the wrap.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_write(A_TERM, 32'd2);
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_write(A_CTRL, 32'h3);
    begin
      logic [31:0] wrap_exp [5];
      wrap_exp = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd0};
      for (int e = 1; e <= 5; e++) begin
        tick();
        chk_reg($sformatf("wrap_count_e%0d", e), A_COUNT, wrap_exp[e-1]);
        chk_reg($sformatf("wrap_pend_e%0d", e), A_STATUS, (e == 5) ? 32'd1 : 32'd0);
      end
    end

    // Decode: +0x10 is outside the window; low address bits are ignored.
    bus_write(A_CTRL, 32'h0);
    bus_write(A_TERM, 32'h1234);
    bus_write(BASE + 32'h10, 32'hFFFF_FFFF);
    addr = BASE + 32'h10;
    #1;
    check("dec_miss_hit", {31'd0, rd_hit}, 32'd0);
    check("dec_miss_data", rd_data, 32'd0);
    addr = A_TERM;
    #1;
    check("dec_term_hit", {31'd0, rd_hit}, 32'd1);
    check("dec_term_data", rd_data, 32'h1234);
    chk_reg("dec_term_b3", BASE + 32'h7, 32'h1234);
    chk_reg("dec_ctrl", A_CTRL, 32'h0);
    chk_reg("dec_count", A_COUNT, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
